// File: rtl/reg_dump_uart_tx.sv
// Debug serial output: walks the register file and sends each register as lowercase hex + CR LF over UART.
// Optional feature macro: DSO_PARITY_EN (adds an even-parity bit, 8E1 instead of 8N1).
module reg_dump_uart_tx #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned REG_CNT      = 32,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    output logic [4:0]      o_reg_addr,
    input  logic [XLEN-1:0] i_reg_data,
    output logic            o_tx,
    output logic            o_busy,
    output logic            o_done
);

    localparam int unsigned DIGITS = XLEN / 4;
    localparam int unsigned DIG_W  = $clog2(DIGITS);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]        ADDR_LAST = 5'(REG_CNT - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef DSO_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {PH_DIGIT, PH_CR, PH_LF, PH_END} phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [1:0]        sync_q, sync_d;
    logic              start_prev_q, start_prev_d;
    logic [XLEN-1:0]   snap_q, snap_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic [7:0]        byte_q, byte_d;
    logic [2:0]        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [4:0]        addr_q, addr_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_edge_c;
    logic              baud_last_c;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'(8'h30 + {4'h0, n}) : 8'(8'h57 + {4'h0, n});
    endfunction

    assign start_edge_c = sync_q[1] & ~start_prev_q;
    assign baud_last_c  = (baud_q == BAUD_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_DIGIT;
            sync_q       <= '0;
            start_prev_q <= 1'b0;
            snap_q       <= '0;
            dig_q        <= '0;
            byte_q       <= '0;
            bit_q        <= '0;
            baud_q       <= '0;
            addr_q       <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            sync_q       <= sync_d;
            start_prev_q <= start_prev_d;
            snap_q       <= snap_d;
            dig_q        <= dig_d;
            byte_q       <= byte_d;
            bit_q        <= bit_d;
            baud_q       <= baud_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state and datapath; registered outputs are derived from the next state.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        sync_d       = {sync_q[0], i_start};
        start_prev_d = sync_q[1];
        snap_d       = snap_q;
        dig_d        = dig_q;
        byte_d       = byte_q;
        bit_d        = bit_q;
        baud_d       = baud_q;
        addr_d       = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start_edge_c) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                end
            end
            ST_FETCH: begin
                snap_d  = i_reg_data;
                dig_d   = DIG_LAST;
                phase_d = PH_DIGIT;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = ST_START;
                case (phase_q)
                    PH_DIGIT: begin
                        byte_d = hex_char(snap_q[XLEN-1 -: 4]);
                        snap_d = snap_q << 4;
                        if (dig_q == '0) begin
                            phase_d = PH_CR;
                        end else begin
                            dig_d = DIG_W'(dig_q - 1'b1);
                        end
                    end
                    PH_CR: begin
                        byte_d  = 8'h0d;
                        phase_d = PH_LF;
                    end
                    default: begin
                        byte_d  = 8'h0a;
                        phase_d = PH_END;
                    end
                endcase
            end
            ST_START: begin
                baud_d = BAUD_W'(baud_q + 1'b1);
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                baud_d = BAUD_W'(baud_q + 1'b1);
                if (baud_last_c) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef DSO_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = 3'(bit_q + 1'b1);
                    end
                end
            end
`ifdef DSO_PARITY_EN
            ST_PARITY: begin
                baud_d = BAUD_W'(baud_q + 1'b1);
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                baud_d = BAUD_W'(baud_q + 1'b1);
                if (baud_last_c) begin
                    baud_d = '0;
                    if (phase_q != PH_END) begin
                        state_d = ST_LOAD;
                    end else if (addr_q == ADDR_LAST) begin
                        state_d = ST_DONE;
                        addr_d  = '0;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                addr_d  = 5'(addr_q + 1'b1);
                state_d = ST_FETCH;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = byte_d[bit_d];
`ifdef DSO_PARITY_EN
            ST_PARITY: tx_d = ^byte_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    assign o_reg_addr = addr_q;
    assign o_tx       = tx_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Testbench for reg_dump_uart_tx: UART monitor decodes o_tx into a queue, scoreboard holds expected chars.
module tb_reg_dump_uart_tx;

    localparam int unsigned CPB        = 4;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_CNT    = 32;
    localparam int unsigned DIGITS     = XLEN / 4;
    localparam int unsigned DUMP_CHARS = REG_CNT * (DIGITS + 2);
`ifdef DSO_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned CHAR_GAP    = FRAME_BITS * CPB + 1;
    localparam int unsigned LINE_GAP    = CHAR_GAP + 2;
    localparam int unsigned DUMP_BUDGET = DUMP_CHARS * (CHAR_GAP + 1) + 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        tx, busy, done;
    logic [31:0] regs [REG_CNT];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_busy_bad = 0;
    int frame_err = 0;
    int frame_err_base = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    int         stamp_q [$];
    string      hexs = "0123456789abcdef";

    reg_dump_uart_tx #(.XLEN(XLEN), .REG_CNT(REG_CNT), .CLKS_PER_BIT(CPB)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .o_reg_addr (reg_addr),
        .i_reg_data (reg_data),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_done     (done)
    );

    assign reg_data = regs[reg_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (busy) done_busy_bad++;
        end
    end

    task automatic mon_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // UART receiver: start detected at bit offset 0, every later bit sampled mid-bit.
    initial begin : uart_mon
        logic [7:0] ch;
        int st;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && tx === 1'b0) begin
                st = cyc;
                mon_wait(CPB / 2);
                if (tx !== 1'b0) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB);
                    ch[i] = tx;
                end
`ifdef DSO_PARITY_EN
                mon_wait(CPB);
                if (tx !== ^ch) frame_err++;
`endif
                mon_wait(CPB);
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(ch);
                stamp_q.push_back(st);
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_dump();
        for (int r = 0; r < int'(REG_CNT); r++) begin
            for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
                exp_q.push_back(hexs[regs[r][d*4 +: 4]]);
            end
            exp_q.push_back(8'h0d);
            exp_q.push_back(8'h0a);
        end
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start = 1'b1;
        repeat (n) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < int'(DUMP_BUDGET)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL %s_timeout: no o_done within %0d cycles", name, DUMP_BUDGET);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_addr(input string name, input logic [4:0] a);
        int n;
        n = 0;
        while (reg_addr !== a && n < int'(DUMP_BUDGET)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (reg_addr !== a) begin
            errors++;
            $display("FAIL %s_addr_timeout: got %0d need %0d", name, reg_addr, a);
        end
    endtask

    task automatic check_rx(input string name);
        int idx;
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d chars need %0d", name, rx_q.size(), exp_q.size());
        end
        checks++;
        if (frame_err != frame_err_base) begin
            errors++;
            $display("FAIL %s_framing: got %0d frame errors need 0", name, frame_err - frame_err_base);
        end
        idx = 0;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] got, want;
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s_char[%0d]: got %02h need %02h", name, idx, got, want);
            end
            idx++;
        end
        rx_q.delete();
        exp_q.delete();
        stamp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = ~start;
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || reg_addr !== 5'd0) begin
                errors++;
                $display("FAIL reset_state: got tx=%b busy=%b done=%b addr=%0d need 1 0 0 0",
                         tx, busy, done, reg_addr);
            end
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b chars=%0d need 0 0", busy, rx_q.size());
        end
    endtask

    task automatic test_basic();
        int base;
        for (int r = 0; r < int'(REG_CNT); r++) regs[r] = 32'h0;
        regs[1] = 32'h0000_00ff;
        push_dump();
        base = done_cnt;
        pulse_start(3);
        wait_done("basic", base);
        checks++;
        if (done_cnt - base != 1 || done_busy_bad != 0) begin
            errors++;
            $display("FAIL basic_done: got pulses=%0d busy_at_done=%0d need 1 0",
                     done_cnt - base, done_busy_bad);
        end
        checks++;
        if (busy !== 1'b0 || reg_addr !== 5'd0) begin
            errors++;
            $display("FAIL basic_idle: got busy=%b addr=%0d need 0 0", busy, reg_addr);
        end
        if (stamp_q.size() > 10) begin
            checks++;
            if (stamp_q[1] - stamp_q[0] != int'(CHAR_GAP)) begin
                errors++;
                $display("FAIL basic_char_period: got %0d need %0d", stamp_q[1] - stamp_q[0], CHAR_GAP);
            end
            checks++;
            if (stamp_q[10] - stamp_q[9] != int'(LINE_GAP)) begin
                errors++;
                $display("FAIL basic_line_period: got %0d need %0d", stamp_q[10] - stamp_q[9], LINE_GAP);
            end
        end
        check_rx("basic");
    endtask

    task automatic test_hex();
        int base;
        regs[2]  = 32'h0123_4567;
        regs[3]  = 32'h89ab_cdef;
        regs[30] = 32'h9a00_0000;
        regs[31] = 32'hdead_beef;
        push_dump();
        base = done_cnt;
        pulse_start(3);
        // Changing reg31 after its fetch must not alter the line already snapshotted.
        wait_addr("hex", 5'd31);
        repeat (10) @(negedge clk);
        regs[31] = 32'h1234_5678;
        wait_done("hex", base);
        check_rx("hex");
        regs[31] = 32'hdead_beef;
    endtask

    task automatic test_held();
        int base;
        push_dump();
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        repeat (5000) @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_busy: got %b need 1", busy);
        end
        for (int i = 0; i < 3; i++) begin
            repeat (200) @(negedge clk);
            pulse_start(3);
        end
        wait_done("held", base);
        repeat (500) @(negedge clk);
        checks++;
        if (done_cnt - base != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_single_dump: got pulses=%0d busy=%b need 1 0", done_cnt - base, busy);
        end
        check_rx("held");
    endtask

    task automatic test_reset_mid();
        int base;
        int n;
        pulse_start(3);
        wait_addr("rstmid", 5'd5);
        n = 0;
        @(posedge clk);
        #1;
        while (tx !== 1'b0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_start_timeout: got tx=%b need 0", tx);
        end
        // Start bit occupies offsets 0..CPB-1; land in the middle of data bit 3.
        repeat (CPB + 3 * CPB + CPB / 2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || reg_addr !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_async: got tx=%b busy=%b addr=%0d need 1 0 0", tx, busy, reg_addr);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rx_q.delete();
        stamp_q.delete();
        exp_q.delete();
        frame_err_base = frame_err;
        checks++;
        if (busy !== 1'b0 || reg_addr !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_idle: got busy=%b addr=%0d need 0 0", busy, reg_addr);
        end
        push_dump();
        base = done_cnt;
        pulse_start(3);
        wait_done("rstmid_redump", base);
        check_rx("rstmid_redump");
    endtask

    initial begin : main
        for (int r = 0; r < int'(REG_CNT); r++) regs[r] = 32'h0;
        test_reset();
        test_basic();
        test_hex();
        test_held();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
